// File: rtl/sv32_page_table_walker_if.sv
// Translator-facing walk handshake plus the walker's single memory read port.
interface sv32_page_table_walker_if;
  logic        walk_valid;
  logic        walk_ready;
  logic [31:0] address;
  logic [31:0] satp;
  logic [31:0] pte;
  logic        walk_fault;
  logic        mem_valid;
  logic        mem_ready;
  logic [33:0] mem_addr;
  logic [31:0] mem_rdata;

  modport slave (
    input  walk_valid, address, satp, mem_ready, mem_rdata,
    output walk_ready, pte, walk_fault, mem_valid, mem_addr
  );

  modport master (
    output walk_valid, address, satp, mem_ready, mem_rdata,
    input  walk_ready, pte, walk_fault, mem_valid, mem_addr
  );
endinterface

// File: rtl/sv32_page_table_walker.sv
// Two-level SV32 page-table walker: one PTE read per level, one result word
// holding the leaf page base and flags, or zero on any fault.
module sv32_page_table_walker (
  input  logic                      clk,
  input  logic                      reset,
  sv32_page_table_walker_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, LVL1, LVL0, DONE} state_e;

  typedef struct packed {
    logic        fault;
    logic        descend;
    logic [19:0] page;
  } eval_t;

  state_e      state_q, state_d;
  logic [19:0] vpn_q, vpn_d;
  logic [21:0] root_q, root_d;
  logic [21:0] ppn1_q, ppn1_d;
  logic [31:0] pte_q, pte_d;
  logic        fault_q, fault_d;
  eval_t       ev;
  logic        unused_bits;

  assign unused_bits = ^{bus.satp[31:22], bus.address[11:0]};

  function automatic eval_t eval_pte(input logic [31:0] p, input logic lvl1,
                                     input logic [9:0] vpn0);
    eval_t       r;
    logic [21:0] ppn;
    r   = '0;
    ppn = p[31:10];
    if (!p[0] || (p[2] && !p[1])) begin
      r.fault = 1'b1;
    end else if (!p[1] && !p[3]) begin
      r.descend = lvl1;
      r.fault   = !lvl1;
    end else if ((ppn[21:20] != 2'b00) || (lvl1 && (ppn[9:0] != 10'd0))) begin
      r.fault = 1'b1;
    end else begin
      r.page = lvl1 ? {ppn[19:10], vpn0} : ppn[19:0];
    end
    return r;
  endfunction

  assign ev = eval_pte(bus.mem_rdata, state_q == LVL1, vpn_q[9:0]);

  always_comb begin
    state_d        = state_q;
    vpn_d          = vpn_q;
    root_d         = root_q;
    ppn1_d         = ppn1_q;
    pte_d          = pte_q;
    fault_d        = fault_q;
    bus.mem_valid  = 1'b0;
    bus.mem_addr   = '0;
    bus.walk_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.walk_valid) begin
          vpn_d   = bus.address[31:12];
          root_d  = bus.satp[21:0];
          state_d = LVL1;
        end
      end
      LVL1, LVL0: begin
        bus.mem_valid = 1'b1;
        // PTE address is base page plus VPN*4, 34-bit, carry out dropped
        if (state_q == LVL1)
          bus.mem_addr = {root_q, 12'b0} + {22'b0, vpn_q[19:10], 2'b00};
        else
          bus.mem_addr = {ppn1_q, 12'b0} + {22'b0, vpn_q[9:0], 2'b00};
        if (bus.mem_ready) begin
          if (ev.descend) begin
            ppn1_d  = bus.mem_rdata[31:10];
            state_d = LVL0;
          end else begin
            pte_d   = ev.fault ? 32'd0 : {ev.page, 4'b0, bus.mem_rdata[7:0]};
            fault_d = ev.fault;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        bus.walk_ready = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      vpn_q   <= '0;
      root_q  <= '0;
      ppn1_q  <= '0;
      pte_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vpn_q   <= vpn_d;
      root_q  <= root_d;
      ppn1_q  <= ppn1_d;
      pte_q   <= pte_d;
      fault_q <= fault_d;
    end
  end

  assign bus.pte        = pte_q;
  assign bus.walk_fault = fault_q;

endmodule

// File: tb/tb_sv32_page_table_walker.sv
// Bench for the SV32 walker: directed walks from the test plan plus random
// page tables, checked against a functional walk model over a sparse memory.
module tb_sv32_page_table_walker;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sv32_page_table_walker_if bus ();

  sv32_page_table_walker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          tests = 0;
  int          fails = 0;
  bit [31:0]   mem [bit [33:0]];
  int          waits = 0;
  bit          spurious = 1'b0;
  bit [33:0]   rd_log [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] rd(input bit [33:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Functional SV32 walk: reads the sparse memory directly
  function automatic void model(input bit [31:0] s, input bit [31:0] a,
                                output bit [31:0] epte, output bit efault,
                                output int nrd, output bit [33:0] a1,
                                output bit [33:0] a0);
    bit [31:0] p;
    bit [21:0] ppn;
    a1 = {s[21:0], 12'h000} + 34'(a[31:22]) * 4;
    a0 = '0;
    p = rd(a1); nrd = 1; efault = 1'b1; epte = 32'h0;
    ppn = p[31:10];
    if (p[0] == 1'b0 || (p[2] && !p[1])) return;
    if (!p[1] && !p[3]) begin
      a0 = {ppn, 12'h000} + 34'(a[21:12]) * 4;
      p = rd(a0); nrd = 2; ppn = p[31:10];
      if (p[0] == 1'b0 || (p[2] && !p[1]) || (!p[1] && !p[3]) || ppn[21:20] != 2'b00) return;
      epte = {ppn[19:0], 4'h0, p[7:0]};
    end else begin
      if (ppn[9:0] != 10'd0 || ppn[21:20] != 2'b00) return;
      epte = {ppn[19:10], a[21:12], 4'h0, p[7:0]};
    end
    efault = 1'b0;
  endfunction

  function automatic bit [31:0] mk_pte(input int kind);
    bit [31:0] r;
    bit [31:0] p;
    r = $urandom;
    case (kind)
      0:       p = {r[31:4], 4'b0001};
      1:       p = {2'b00, r[29:20], 10'b0, r[9:4], r[3:2], 2'b11};
      2:       p = {2'b00, r[29:4], r[3:2], 2'b11};
      default: p = r;
    endcase
    return p;
  endfunction

  // Memory responder: waits cycles before each ready, checks mem_addr holds
  initial begin
    bit        in_req;
    bit [33:0] req_addr;
    int        wcnt;
    in_req = 1'b0; wcnt = 0; req_addr = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      bus.mem_rdata = $urandom;
      if (reset || !bus.mem_valid) begin
        in_req = 1'b0;
        if (spurious) bus.mem_ready = 1'b1;
      end else begin
        if (!in_req) begin
          in_req = 1'b1; req_addr = bus.mem_addr; wcnt = 0;
        end else begin
          chk("mem_addr_stable", 64'(bus.mem_addr), 64'(req_addr));
        end
        if (wcnt == waits) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = rd(req_addr);
          rd_log.push_back(req_addr);
          in_req = 1'b0;
        end else begin
          wcnt++;
        end
      end
    end
  end

  task automatic run_walk(input string tag, input bit [31:0] s, input bit [31:0] a,
                          input int w, output int lat);
    bit [31:0] epte;
    bit        efault;
    int        nrd;
    bit [33:0] a1, a0;
    model(s, a, epte, efault, nrd, a1, a0);
    rd_log.delete();
    waits = w;
    @(negedge clk);
    bus.satp = s; bus.address = a; bus.walk_valid = 1'b1;
    @(negedge clk);
    lat = 1;
    while (!bus.walk_ready && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    bus.walk_valid = 1'b0;
    chk({tag, ".latency"}, 64'(lat), 64'(nrd * (w + 1) + 1));
    chk({tag, ".pte"}, 64'(bus.pte), 64'(epte));
    chk({tag, ".fault"}, 64'(bus.walk_fault), 64'(efault));
    chk({tag, ".reads"}, 64'(rd_log.size()), 64'(nrd));
    if (rd_log.size() >= 1) chk({tag, ".addr1"}, 64'(rd_log[0]), 64'(a1));
    if (rd_log.size() >= 2 && nrd == 2) chk({tag, ".addr0"}, 64'(rd_log[1]), 64'(a0));
    @(negedge clk);
    chk({tag, ".pte_hold"}, 64'(bus.pte), 64'(epte));
    chk({tag, ".ready_pulse"}, 64'(bus.walk_ready), 64'd0);
  endtask

  localparam bit [31:0] SATP = 32'h8008_0000;
  localparam bit [31:0] VA   = 32'h0040_1234;
  localparam bit [33:0] L1A  = 34'h0_8000_0004;
  localparam bit [33:0] L0A  = 34'h0_8000_1004;

  initial begin
    int        lat;
    int        n;
    bit [31:0] s, a, p1;
    bit [33:0] a1, a0;
    reset = 1'b1;
    bus.walk_valid = 1'b0; bus.address = '0; bus.satp = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.walk_ready", 64'(bus.walk_ready), 64'd0);
    chk("rst.mem_valid", 64'(bus.mem_valid), 64'd0);
    chk("rst.mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst.pte", 64'(bus.pte), 64'd0);
    chk("rst.fault", 64'(bus.walk_fault), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    mem.delete(); mem[L1A] = 32'h2000_0401; mem[L0A] = 32'h2004_8CCF;
    run_walk("two_level", SATP, VA, 0, lat);
    chk("two_level.const", 64'(bus.pte), 64'h8012_30CF);
    chk("two_level.lat3", 64'(lat), 64'd3);

    mem.delete(); mem[L1A] = 32'h2010_00CB;
    run_walk("superpage", SATP, VA, 0, lat);
    chk("superpage.const", 64'(bus.pte), 64'h8040_10CB);
    chk("superpage.lat2", 64'(lat), 64'd2);

    mem.delete(); mem[L1A] = 32'h2010_04CB;
    run_walk("misaligned", SATP, VA, 0, lat);
    chk("misaligned.fault", 64'(bus.walk_fault), 64'd1);

    mem.delete(); mem[L1A] = 32'h0;
    run_walk("invalid", SATP, VA, 0, lat);
    chk("invalid.fault", 64'(bus.walk_fault), 64'd1);

    mem.delete(); mem[L1A] = 32'h2000_0401; mem[L0A] = 32'hC000_000F;
    run_walk("overflow_l0", SATP, VA, 0, lat);
    chk("overflow_l0.fault", 64'(bus.walk_fault), 64'd1);

    mem.delete(); mem[L1A] = 32'hC000_000F;
    run_walk("overflow_l1", SATP, VA, 0, lat);

    mem.delete(); mem[L1A] = 32'h2000_0401; mem[L0A] = 32'h2000_0001;
    run_walk("nonleaf_l0", SATP, VA, 0, lat);
    chk("nonleaf_l0.fault", 64'(bus.walk_fault), 64'd1);

    mem.delete(); mem[L1A] = 32'h2000_0401; mem[L0A] = 32'h2004_8CCF;
    run_walk("waits3", SATP, VA, 3, lat);
    chk("waits3.lat9", 64'(lat), 64'd9);

    // Reset while the level-0 read is outstanding
    waits = 3;
    @(negedge clk);
    bus.satp = SATP; bus.address = VA; bus.walk_valid = 1'b1;
    n = 0;
    while (!(bus.mem_valid && bus.mem_addr == L0A) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("midrst.reached_l0", 64'(bus.mem_valid && bus.mem_addr == L0A), 64'd1);
    reset = 1'b1; bus.walk_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst.mem_valid", 64'(bus.mem_valid), 64'd0);
    chk("midrst.mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("midrst.pte", 64'(bus.pte), 64'd0);
    chk("midrst.fault", 64'(bus.walk_fault), 64'd0);
    chk("midrst.walk_ready", 64'(bus.walk_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_walk("after_rst", SATP, VA, 0, lat);

    // Stray mem_ready outside the read states must be ignored
    spurious = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("spurious.mem_valid", 64'(bus.mem_valid), 64'd0);
      chk("spurious.walk_ready", 64'(bus.walk_ready), 64'd0);
    end
    mem.delete(); mem[L1A] = 32'h2010_00CB;
    run_walk("spurious_walk", SATP, VA, 1, lat);
    spurious = 1'b0;

    for (int i = 0; i < 40; i++) begin
      mem.delete();
      s = $urandom; a = $urandom;
      a1 = {s[21:0], 12'h000} + 34'(a[31:22]) * 4;
      p1 = mk_pte($urandom_range(0, 3));
      mem[a1] = p1;
      a0 = {p1[31:10], 12'h000} + 34'(a[21:12]) * 4;
      mem[a0] = mk_pte($urandom_range(0, 3));
      run_walk($sformatf("rand%0d", i), s, a, $urandom_range(0, 2), lat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sv32_page_table_walker.md
# sv32_page_table_walker

Responder side of the SV32 page-table-walk handshake used by the instruction and data translators. On a `walk_valid` request, it performs the two-level SV32 walk rooted at `satp.PPN` through a single memory read port. It returns one 32-bit result word: the leaf physical page base in bits [31:12] and the leaf flags in bits [7:0], or all-zero on any walk fault. The block sits between the translators and the memory arbiter, alongside the CPU data port.

## Interface
- No parameters.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `address` in 32: virtual address to translate; sampled on accept.
- `satp` in 32: root PPN in [21:0]; sampled on accept. The mode bit is checked upstream and ignored here.
- `walk_valid` in 1: request; held high by the initiator until `walk_ready`.
- `walk_ready` out 1: one-cycle pulse; the walk is complete.
- `pte` out 32: result word; registered and held until the next accept.
- `walk_fault` out 1: registered; high when `pte` is the fault value 0.
- `mem_valid` out 1: read request.
- `mem_ready` in 1: read complete; `mem_rdata` is valid in the same cycle.
- `mem_addr` out 34: physical byte address of the PTE.
- `mem_rdata` in 32: raw PTE read from memory.

## Operation
- States: IDLE, LVL1, LVL0, DONE.
- IDLE:
  - If `walk_valid`, latch `address` and `satp.PPN`, then go to LVL1.
- LVL1:
  - Drive `mem_valid=1` and `mem_addr = {satp.PPN,12'b0} + VPN1*4`, where VPN1 = `address`[31:22].
  - Wait while `mem_ready=0`; hold `mem_addr` stable.
  - On `mem_ready`, evaluate `mem_rdata` as the level-1 PTE.
- LVL0:
  - Drive `mem_addr = {PTE1.PPN[21:0],12'b0} + VPN0*4`, where VPN0 = `address`[21:12].
  - Evaluate the level-0 PTE the same way as in LVL1.
- PTE evaluation (V=bit0, R=1, W=2, X=3, PPN=[31:10]):
  - Fault if V=0, or if W=1 with R=0.
  - Non-leaf (R=0, X=0): in LVL1, go to LVL0. In LVL0, fault.
  - Leaf at level 1 (superpage): fault if PPN[9:0]≠0 (misaligned). Otherwise PA page = {PPN[19:10], VPN0}.
  - Leaf at level 0: PA page = PPN[19:0].
  - Any leaf with PPN[21:20]≠0 (PA beyond 32 bits) faults.
  - Success: `pte` ← {PA page[19:0], 4'b0, PTE[7:0]}, `walk_fault`←0.
  - Fault: `pte`←0, `walk_fault`←1. This guarantees the initiator's X/U checks fault.
  - Every success or fault goes to DONE.
- DONE:
  - `walk_ready=1` for exactly one cycle, then go to IDLE.
  - `walk_valid` is not sampled in DONE.
- No permission checks are done here; A/D bits are passed through untouched and never written back.
- Address arithmetic is 34-bit with no carry out; the PPN is zero-extended.

## Timing
- Reset values: state IDLE, `walk_ready`=0, `mem_valid`=0, `mem_addr`=0, `pte`=0, `walk_fault`=0.
- `walk_ready`, `mem_valid` and `mem_addr` decode from registered state and latched operands only. No combinational path from `walk_valid` or `mem_rdata`.
- Latency from the accept cycle (T0) with zero-wait memory:
  - Superpage or L1 fault: `walk_ready` at T0+2.
  - Two-level walk: `walk_ready` at T0+3.
  - Each memory wait cycle adds one cycle.
- `pte` is valid from the `walk_ready` cycle onward. It must still be stable one cycle later, because the initiator samples in its next state.
- Back-to-back requests: the earliest next accept is the cycle after DONE.
- A `mem_ready` arriving while not in LVL1 or LVL0 is ignored.
- Reset asserted mid-walk: the next edge returns to IDLE with all outputs at their reset values, and `mem_valid` drops. Any memory response still in flight is discarded by the arbiter.

## Test plan
- Two-level walk:
  - Stimulus: satp=0x8008_0000, address=0x0040_1234. Memory returns 0x2000_0401 at 0x8000_0004 and 0x2004_8CCF at 0x8000_1004.
  - Required: `pte`=0x8012_30CF, `walk_fault`=0, `walk_ready` at T0+3.
- Superpage walk:
  - Stimulus: same address; memory returns 0x2010_00CB at 0x8000_0004.
  - Required: exactly one memory read, `pte`=0x8040_10CB, `walk_ready` at T0+2.
- Misaligned superpage:
  - Stimulus: L1 PTE 0x2010_04CB (PPN 0x80401).
  - Required: `pte`=0, `walk_fault`=1.
- Invalid PTE and PA overflow:
  - Stimulus A: L1 PTE 0x0000_0000. Required: fault after one read.
  - Stimulus B: leaf PTE with PPN=0x300000. Required: fault.
  - Stimulus C: non-leaf PTE at L0. Required: fault.
- Memory wait states:
  - Stimulus: `mem_ready` delayed 3 cycles on each access.
  - Required: `mem_addr` stable throughout each wait; `walk_ready` at T0+9.
- Reset mid-walk:
  - Stimulus: `reset` asserted while in LVL0 with `mem_valid`=1.
  - Required: next cycle IDLE, `mem_valid`=0, `pte`=0. A following request completes normally.
